// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port valid/ready arbiter sharing one ram data port, one transaction in flight.
// Define DMEM_ARB_CORE_PRIO_EN for fixed core priority instead of round-robin.
module dmem_arbiter #(
  parameter int ADDRW = 14,
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [ADDRW-1:0] req_addr0,
  input  logic [ADDRW-1:0] req_addr1,
  input  logic [DATAW-1:0] req_wdata0,
  input  logic [DATAW-1:0] req_wdata1,
  input  logic [1:0]       req_wsize0,
  input  logic [1:0]       req_wsize1,
  output logic [1:0]       rsp_valid,
  output logic [DATAW-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic [ADDRW-1:0] m_addr,
  output logic [DATAW-1:0] m_wdata,
  output logic [1:0]       m_wsize,
  input  logic [DATAW-1:0] m_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic id, rr_last, err, both_gnt, gnt, accept, mis;
  logic [ADDRW-1:0] sel_addr;
  logic [DATAW-1:0] sel_wdata;
  logic [1:0] sel_wsize;
`ifdef DMEM_ARB_CORE_PRIO_EN
  assign both_gnt = 1'b0;
`else
  assign both_gnt = ~rr_last;
`endif
  always_comb begin
    gnt = &req_valid ? both_gnt : req_valid[1];
    req_ready = (state == IDLE && !resetn && |req_valid) ? {gnt, ~gnt} : 2'b00;
    accept = |req_ready;
    sel_addr = gnt ? req_addr1 : req_addr0;
    sel_wdata = gnt ? req_wdata1 : req_wdata0;
    sel_wsize = gnt ? req_wsize1 : req_wsize0;
    // writes that would straddle a ram word are dropped and reported
    mis = (sel_wsize == 2'b10 && sel_addr[1:0] == 2'b11) ||
          (sel_wsize == 2'b11 && sel_addr[1:0] != 2'b00);
    state_nx = state;
    state_nx = state == IDLE ? (accept ? ACCESS : IDLE) :
               state == ACCESS ? RESP : IDLE;
    rsp_valid = state == RESP ? (id ? 2'b10 : 2'b01) : 2'b00;
    rsp_err = state == RESP && err;
    rsp_data = m_rdata;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (resetn) begin
      state <= IDLE;
      id <= 1'b0;
      rr_last <= 1'b1;
      err <= 1'b0;
      m_addr <= '0;
      m_wdata <= '0;
      m_wsize <= 2'b00;
    end else begin
      state <= state_nx;
      if (accept) begin
        id <= gnt;
        rr_last <= gnt;
        err <= mis;
        m_addr <= sel_addr;
        m_wdata <= sel_wdata;
        m_wsize <= mis ? 2'b00 : sel_wsize;
      end else begin
        m_wsize <= 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven check of dmem_arbiter against a small byte-lane ram model.
module tb_dmem_arbiter;
  logic        clk = 0, resetn = 0;
  logic [1:0]  req_valid = 0, req_ready, rsp_valid, m_wsize;
  logic [13:0] req_addr0 = 0, req_addr1 = 0, m_addr;
  logic [31:0] req_wdata0 = 0, req_wdata1 = 0, rsp_data, m_wdata, m_rdata;
  logic [1:0]  req_wsize0 = 0, req_wsize1 = 0;
  logic        rsp_err, busy;
  int n_cmp = 0, n_fail = 0;

  dmem_arbiter dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_wsize0(req_wsize0), .req_wsize1(req_wsize1), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .m_addr(m_addr), .m_wdata(m_wdata), .m_wsize(m_wsize),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // ram model: registered read, byte-lane write selected by dw_size and addr[1:0]
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    logic [3:0] be;
    logic [31:0] wd;
    be = m_wsize == 2'b01 ? 4'b0001 << m_addr[1:0] :
         m_wsize == 2'b10 ? 4'b0011 << m_addr[1:0] :
         m_wsize == 2'b11 ? 4'b1111 : 4'b0000;
    wd = m_wdata << (8 * m_addr[1:0]);
    for (int b = 0; b < 4; b++)
      if (be[b]) mem[m_addr[13:2]][8*b +: 8] <= wd[8*b +: 8];
    m_rdata <= mem[m_addr[13:2]];
  end

  typedef struct {
    logic [1:0]  vld;
    logic [13:0] a0; logic [31:0] d0; logic [1:0] s0;
    logic [13:0] a1; logic [31:0] d1; logic [1:0] s1;
    logic [1:0]  gnt; logic [1:0] wsz; logic err; logic chk; logic [31:0] data;
  } vec_t;
  vec_t v [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1;
    req_valid = 2'b11;
    #1 chk("ready_in_reset", {30'b0, req_ready}, 0);
    @(negedge clk);
    chk("rst_ready", {30'b0, req_ready}, 0);
    chk("rst_rsp_valid", {30'b0, rsp_valid}, 0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_m_addr", {18'b0, m_addr}, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_wsize", {30'b0, m_wsize}, 0);
    resetn = 0;
    req_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    v[0]  = '{2'b01, 14'h020, 32'h11111111, 2'b11, 14'h000, 32'h0, 2'b00, 2'b01, 2'b11, 1'b0, 1'b0, 32'h0};
    v[1]  = '{2'b10, 14'h000, 32'h0, 2'b00, 14'h024, 32'h22222222, 2'b11, 2'b10, 2'b11, 1'b0, 1'b0, 32'h0};
`ifdef DMEM_ARB_CORE_PRIO_EN
    v[2]  = '{2'b11, 14'h020, 32'h0, 2'b00, 14'h024, 32'h0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 32'h11111111};
    v[3]  = '{2'b11, 14'h020, 32'h0, 2'b00, 14'h024, 32'h0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 32'h11111111};
`else
    v[2]  = '{2'b11, 14'h020, 32'h0, 2'b00, 14'h024, 32'h0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 32'h11111111};
    v[3]  = '{2'b11, 14'h020, 32'h0, 2'b00, 14'h024, 32'h0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 32'h22222222};
`endif
    v[4]  = v[2];
    v[5]  = v[3];
    v[6]  = '{2'b01, 14'h010, 32'hDEADBEEF, 2'b11, 14'h000, 32'h0, 2'b00, 2'b01, 2'b11, 1'b0, 1'b0, 32'h0};
    v[7]  = '{2'b10, 14'h000, 32'h0, 2'b00, 14'h010, 32'h0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 32'hDEADBEEF};
    v[8]  = '{2'b01, 14'h013, 32'h00001234, 2'b10, 14'h000, 32'h0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0};
    v[9]  = '{2'b01, 14'h010, 32'h0, 2'b00, 14'h000, 32'h0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 32'hDEADBEEF};
    v[10] = '{2'b10, 14'h000, 32'h0, 2'b00, 14'h011, 32'h000000AA, 2'b01, 2'b10, 2'b01, 1'b0, 1'b0, 32'h0};
    v[11] = '{2'b01, 14'h010, 32'h0, 2'b00, 14'h000, 32'h0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 32'hDEADAAEF};
    v[12] = '{2'b10, 14'h000, 32'h0, 2'b00, 14'h012, 32'h0000BEEF, 2'b10, 2'b10, 2'b10, 1'b0, 1'b0, 32'h0};
    v[13] = '{2'b10, 14'h000, 32'h0, 2'b00, 14'h013, 32'h0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 32'hBEEFAAEF};
    v[14] = '{2'b01, 14'h011, 32'h55555555, 2'b11, 14'h000, 32'h0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 32'h0};
    v[15] = '{2'b01, 14'h010, 32'h0, 2'b00, 14'h000, 32'h0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 32'hBEEFAAEF};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i == 2) do_reset();
      @(negedge clk);
      req_valid = v[i].vld;
      req_addr0 = v[i].a0; req_wdata0 = v[i].d0; req_wsize0 = v[i].s0;
      req_addr1 = v[i].a1; req_wdata1 = v[i].d1; req_wsize1 = v[i].s1;
      #1;
      chk($sformatf("v%0d_grant", i), {30'b0, req_ready}, {30'b0, v[i].gnt});
      chk($sformatf("v%0d_idle_busy", i), {31'b0, busy}, 0);
      @(negedge clk);
      chk($sformatf("v%0d_acc_busy", i), {31'b0, busy}, 1);
      chk($sformatf("v%0d_acc_ready", i), {30'b0, req_ready}, 0);
      chk($sformatf("v%0d_acc_rsp", i), {30'b0, rsp_valid}, 0);
      chk($sformatf("v%0d_m_wsize", i), {30'b0, m_wsize}, {30'b0, v[i].wsz});
      chk($sformatf("v%0d_m_addr", i), {18'b0, m_addr}, {18'b0, v[i].gnt[1] ? v[i].a1 : v[i].a0});
      @(negedge clk);
      chk($sformatf("v%0d_rsp_valid", i), {30'b0, rsp_valid}, {30'b0, v[i].gnt});
      chk($sformatf("v%0d_rsp_err", i), {31'b0, rsp_err}, {31'b0, v[i].err});
      chk($sformatf("v%0d_rsp_wsize", i), {30'b0, m_wsize}, 0);
      if (v[i].chk) chk($sformatf("v%0d_rsp_data", i), rsp_data, v[i].data);
    end

    // reset during ACCESS of a read abandons it; a fresh request is served afterwards
    @(negedge clk);
    req_valid = 2'b01; req_addr0 = 14'h010; req_wsize0 = 2'b00;
    @(negedge clk);
    chk("r6_access_busy", {31'b0, busy}, 1);
    resetn = 1;
    @(negedge clk);
    chk("r6_busy", {31'b0, busy}, 0);
    chk("r6_rsp_valid", {30'b0, rsp_valid}, 0);
    chk("r6_m_wsize", {30'b0, m_wsize}, 0);
    chk("r6_ready_rst", {30'b0, req_ready}, 0);
    resetn = 0;
    #1 chk("r6_ready", {30'b0, req_ready}, 2'b01);
    @(negedge clk);
    chk("r6_acc_busy", {31'b0, busy}, 1);
    chk("r6_no_early_rsp", {30'b0, rsp_valid}, 0);
    @(negedge clk);
    chk("r6_rsp", {30'b0, rsp_valid}, 2'b01);
    chk("r6_data", rsp_data, 32'hBEEFAAEF);
    req_valid = 0;
    @(negedge clk);
    chk("r6_idle_rsp", {30'b0, rsp_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
